// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
//   NOP_INSN         : word presented to decode while no instruction is valid
//   PC_RESET_DEFAULT : default first fetch address after reset
//   INSN_BYTES       : fetch stride in bytes
//   fetch_entry_t    : one buffered fetch {instr, pc}
package if_pkg;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          INSN_BYTES       = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/response bus.
//   stb   : request valid (fetch -> memory)
//   addr  : request address, word aligned (fetch -> memory)
//   stall : request not accepted this cycle (memory -> fetch)
//   ack   : response valid, in request order (memory -> fetch)
//   data  : response instruction word (memory -> fetch)
// master = fetch stage, slave = memory.
interface if_prefetch_if #(
  parameter int XLEN = 32
);
  logic            stb;
  logic [XLEN-1:0] addr;
  logic            stall;
  logic            ack;
  logic [XLEN-1:0] data;

  modport master (output stb, addr, input stall, ack, data);
  modport slave  (input stb, addr, output stall, ack, data);
endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush. Used for the PC-tag queue and the
// instruction buffer of the prefetch stage.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the FIFO at the next edge (wins over push/pop)
//   push/wdata : write an entry
//   pop        : drop the head entry
//   rdata      : head entry (undefined while empty)
//   count      : number of stored entries
//   empty/full : occupancy flags
// DEPTH must be a power of two so the pointers wrap for free.
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with pipelined imem requests and an in-order
// prefetch buffer toward decode.
//   clk, rst_n    : clock, synchronous active-low reset
//   imem          : imem bus (master side): stb/addr out, stall/ack/data in
//   i_redirect    : redirect the fetch stream this cycle
//   i_redirect_pc : redirect target; bit 0 is cleared (jalr)
//   o_instr_valid : buffer head valid toward decode
//   o_instr       : head instruction, NOP_INSN when not valid
//   o_pc          : head PC, 0 when not valid
//   i_dec_ready   : decode accepts the head this cycle
// Up to DEPTH words are either buffered or in flight. Responses to requests
// issued before a redirect are counted in kill and discarded on return.
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = if_pkg::PC_RESET_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSN = if_pkg::NOP_INSN
) (
  input  logic             clk,
  input  logic             rst_n,
  if_prefetch_if.master    imem,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  output logic             o_instr_valid,
  output logic [XLEN-1:0]  o_instr,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_dec_ready
);
  import if_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   kill;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   tag_cnt;
  logic [CW:0]     occ;
  logic            fifo_empty, fifo_full, tag_empty, tag_full;
  logic [XLEN-1:0] tag_pc, head_instr, head_pc;
  logic            accept, live_ack, pop;

  // Credit check counts in-flight requests, so an ack always finds room.
  assign occ      = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign imem.stb = rst_n && !i_redirect && (occ < (CW+1)'(DEPTH));
  assign imem.addr = fetch_pc;
  assign accept   = imem.stb && !imem.stall;
  assign live_ack = imem.ack && (kill == '0);
  assign out_next = outstanding + CW'(accept) - CW'(imem.ack);

  assign o_instr_valid = !fifo_empty && !i_redirect;
  assign pop           = o_instr_valid && i_dec_ready;
  assign o_instr       = o_instr_valid ? head_instr : NOP_INSN;
  assign o_pc          = o_instr_valid ? head_pc : '0;

  if_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (accept),
    .wdata (fetch_pc),
    .pop   (live_ack),
    .rdata (tag_pc),
    .count (tag_cnt),
    .empty (tag_empty),
    .full  (tag_full)
  );

  if_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (live_ack),
    .wdata ({imem.data, tag_pc}),
    .pop   (pop),
    .rdata ({head_instr, head_pc}),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= PC_RESET;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      outstanding <= out_next;
      if (i_redirect) begin
        fetch_pc <= i_redirect_pc & ~XLEN'(1);
        // Every request still in flight after this edge belongs to the old
        // stream; this already includes any kill not yet drained.
        kill     <= out_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
        if (imem.ack && (kill != '0)) kill <= kill - CW'(1);
      end
    end
  end

  a_no_spurious_ack: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem.ack && (outstanding == '0)));
  a_kill_bound: assert property (@(posedge clk) disable iff (!rst_n)
    kill <= outstanding);
  a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, tag_cnt} + {1'b0, kill}) == {1'b0, outstanding});
  a_buf_room: assert property (@(posedge clk) disable iff (!rst_n)
    !(live_ack && fifo_full && !pop));
  a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && tag_full));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    !(live_ack && tag_empty));
endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios plus a randomized
// run against a queue-based model of buffered words and in-flight requests.
module tb_if_prefetch;
  import if_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  if_prefetch_if #(.XLEN(XLEN)) imem_bus ();

  if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t         pend[$];     // requests accepted by memory, not yet answered
  fetch_entry_t fifo_q[$];   // words expected to be buffered toward decode
  logic [31:0]  next_fetch;

  int checks = 0;
  int errors = 0;

  // knobs applied at the next drive
  bit          n_rst = 1'b0, n_redir = 1'b0, n_ready = 1'b0, stall_now = 1'b0;
  logic [31:0] n_rpc = '0;
  int          ack_pct = 100;

  // values sampled in the current cycle
  bit          s_acc, s_ack, s_pop, s_redir;
  logic [31:0] s_addr, s_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5a5a_0013;
  endfunction

  task automatic drive();
    @(negedge clk);
    rst_n       = n_rst;
    redirect    = n_redir;
    redirect_pc = n_rpc;
    dec_ready   = n_ready;
    imem_bus.stall = stall_now;
    if (rst_n && pend.size() > 0 && $urandom_range(99) < ack_pct) begin
      imem_bus.ack  = 1'b1;
      imem_bus.data = mem_word(pend[0].addr);
    end else begin
      imem_bus.ack  = 1'b0;
      imem_bus.data = 32'hdead_beef;
    end
    #1;
    s_acc   = imem_bus.stb && !imem_bus.stall;
    s_ack   = imem_bus.ack;
    s_pop   = instr_valid && dec_ready;
    s_redir = redirect;
    s_rpc   = redirect_pc;
    s_addr  = imem_bus.addr;
  endtask

  task automatic advance();
    req_t         r;
    fetch_entry_t e;
    bit           live;
    live = 1'b0;
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      fifo_q.delete();
      next_fetch = PC_RESET_DEFAULT;
      return;
    end
    if (s_ack && pend.size() > 0) begin
      r = pend.pop_front();
      live = !r.stale && !s_redir;
      e.instr = mem_word(r.addr);
      e.pc    = r.addr;
    end
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (live) fifo_q.push_back(e);
    if (s_acc) begin
      pend.push_back('{s_addr, 1'b0});
      next_fetch = next_fetch + 32'd4;
    end
    if (s_redir) begin
      fifo_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      next_fetch = s_rpc & ~32'h1;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0; n_redir = 1'b0; n_ready = 1'b0; stall_now = 1'b0; ack_pct = 100;
    drive(); advance();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; n_redir = 1'b0; n_ready = 1'b1; stall_now = 1'b0; ack_pct = 100;
    drive(); advance();
    drive();
    checks++;
    if (imem_bus.stb !== 1'b0 || imem_bus.addr !== PC_RESET_DEFAULT) begin
      errors++;
      $display("FAIL reset_bus stb=%b addr=%h expected stb=0 addr=%h", imem_bus.stb, imem_bus.addr, PC_RESET_DEFAULT);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP_INSN || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_out valid=%b instr=%h pc=%h expected 0 %h 0", instr_valid, instr, pc, NOP_INSN);
    end
    advance();
    n_rst = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    n_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive();
      checks++;
      if (imem_bus.stb !== 1'b1 || imem_bus.addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr cyc=%0d stb=%b addr=%h expected 1 %h", i, imem_bus.stb, imem_bus.addr, 32'(4 * i));
      end
      checks++;
      if (i < 2) begin
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early cyc=%0d valid=%b expected 0", i, instr_valid);
        end
      end else if (instr_valid !== 1'b1 || pc !== 32'(4 * (i - 2)) || instr !== mem_word(32'(4 * (i - 2)))) begin
        errors++;
        $display("FAIL stream_out cyc=%0d valid=%b pc=%h instr=%h expected 1 %h %h",
                 i, instr_valid, pc, instr, 32'(4 * (i - 2)), mem_word(32'(4 * (i - 2))));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int acc_cnt = 0;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive();
      if (s_acc) acc_cnt++;
      if (i == 9) begin
        checks++;
        if (imem_bus.stb !== 1'b0 || instr_valid !== 1'b1) begin
          errors++;
          $display("FAIL full_stall stb=%b valid=%b expected stb=0 valid=1", imem_bus.stb, instr_valid);
        end
      end
      advance();
    end
    checks++;
    if (acc_cnt != DEPTH) begin
      errors++;
      $display("FAIL full_accepts got=%0d expected=%0d", acc_cnt, DEPTH);
    end
    n_ready = 1'b1;
    for (int i = 0; i < 25 && pops < 6; i++) begin
      drive();
      if (s_pop) begin
        checks++;
        if (pc !== 32'(4 * pops) || instr !== mem_word(32'(4 * pops))) begin
          errors++;
          $display("FAIL drain_order n=%0d pc=%h instr=%h expected %h %h", pops, pc, instr, 32'(4 * pops), mem_word(32'(4 * pops)));
        end
        pops++;
      end
      advance();
    end
    checks++;
    if (pops != 6) begin
      errors++;
      $display("FAIL drain_timeout pops=%0d expected 6", pops);
    end
  endtask

  task automatic test_redirect_inflight();
    int acc_cnt = 0;
    int pops = 0;
    logic [31:0] exp_pc = 32'h100;
    do_reset();
    n_ready = 1'b1;
    ack_pct = 0;
    for (int i = 0; i < 3; i++) begin
      drive();
      if (s_acc) acc_cnt++;
      advance();
    end
    checks++;
    if (acc_cnt != 3) begin
      errors++;
      $display("FAIL inflight_accepts got=%0d expected 3", acc_cnt);
    end
    n_redir = 1'b1; n_rpc = 32'h101;
    drive();
    checks++;
    if (imem_bus.stb !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle stb=%b valid=%b expected 0 0", imem_bus.stb, instr_valid);
    end
    advance();
    n_redir = 1'b0; ack_pct = 100;
    for (int i = 0; i < 20 && pops < 3; i++) begin
      drive();
      if (i == 0) begin
        checks++;
        if (imem_bus.stb !== 1'b1 || imem_bus.addr !== 32'h100) begin
          errors++;
          $display("FAIL redir_target stb=%b addr=%h expected 1 00000100", imem_bus.stb, imem_bus.addr);
        end
      end
      if (s_pop) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redir_stream pc=%h instr=%h expected %h %h", pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
      advance();
    end
    checks++;
    if (pops != 3) begin
      errors++;
      $display("FAIL redir_timeout pops=%0d expected 3", pops);
    end
  endtask

  task automatic test_redirect_with_ack();
    for (int k = 0; k < 6; k++) begin
      int pops = 0;
      logic [31:0] target;
      do_reset();
      n_ready = 1'b1;
      ack_pct = 50;
      for (int i = 0; i < 3 + int'($urandom_range(4)); i++) begin
        drive(); advance();
      end
      ack_pct = 100;
      // odd iterations issue two back-to-back redirects; the second wins
      for (int r = 0; r < 1 + (k % 2); r++) begin
        target = 32'h2000 + ($urandom_range(255) << 2) + 32'(r * 32'h1000) + 32'(k & 1);
        n_redir = 1'b1; n_rpc = target;
        drive();
        checks++;
        if (imem_bus.stb !== 1'b0 || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_ack_cycle it=%0d stb=%b valid=%b expected 0 0", k, imem_bus.stb, instr_valid);
        end
        advance();
      end
      n_redir = 1'b0;
      target = target & ~32'h1;
      for (int i = 0; i < 25 && pops < 4; i++) begin
        drive();
        if (s_pop) begin
          checks++;
          if (pc !== target || instr !== mem_word(target)) begin
            errors++;
            $display("FAIL redir_ack_stream it=%0d pc=%h instr=%h expected %h %h", k, pc, instr, target, mem_word(target));
          end
          target += 32'd4;
          pops++;
        end
        advance();
      end
      checks++;
      if (pops != 4) begin
        errors++;
        $display("FAIL redir_ack_timeout it=%0d pops=%0d expected 4", k, pops);
      end
    end
  endtask

  task automatic test_stall();
    int acc_cnt = 0;
    do_reset();
    n_ready = 1'b1;
    stall_now = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive();
      checks++;
      if (imem_bus.stb !== 1'b1 || imem_bus.addr !== PC_RESET_DEFAULT) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d stb=%b addr=%h expected 1 %h", i, imem_bus.stb, imem_bus.addr, PC_RESET_DEFAULT);
      end
      advance();
    end
    stall_now = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive();
      if (s_acc) begin
        checks++;
        if (s_addr !== 32'(4 * acc_cnt)) begin
          errors++;
          $display("FAIL stall_seq n=%0d addr=%h expected %h", acc_cnt, s_addr, 32'(4 * acc_cnt));
        end
        acc_cnt++;
      end
      advance();
    end
    checks++;
    if (acc_cnt != 6) begin
      errors++;
      $display("FAIL stall_resume accepts=%0d expected 6", acc_cnt);
    end
  endtask

  task automatic test_reset_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(); advance();
    end
    drive();
    checks++;
    if (instr_valid !== 1'b1 || imem_bus.stb !== 1'b0) begin
      errors++;
      $display("FAIL prefull valid=%b stb=%b expected 1 0", instr_valid, imem_bus.stb);
    end
    advance();
    n_rst = 1'b0;
    drive(); advance();
    n_rst = 1'b1; n_ready = 1'b1;
    drive();
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP_INSN || pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_full_out valid=%b instr=%h pc=%h expected 0 %h 0", instr_valid, instr, pc, NOP_INSN);
    end
    checks++;
    if (imem_bus.stb !== 1'b1 || imem_bus.addr !== PC_RESET_DEFAULT) begin
      errors++;
      $display("FAIL rst_full_bus stb=%b addr=%h expected 1 %h", imem_bus.stb, imem_bus.addr, PC_RESET_DEFAULT);
    end
    advance();
  endtask

  task automatic test_random();
    bit exp_stb, exp_valid;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      n_ready   = ($urandom_range(99) < 70);
      stall_now = ($urandom_range(99) < 25);
      ack_pct   = ((i / 200) % 3 == 2) ? 15 : 65;
      n_redir   = ($urandom_range(99) < 4);
      n_rpc     = ($urandom_range(3) == 0) ? (32'hffff_fff0 | 32'($urandom_range(15))) : $urandom;
      drive();
      exp_stb = !redirect && (fifo_q.size() + pend.size() < DEPTH);
      checks++;
      if (imem_bus.stb !== exp_stb) begin
        errors++;
        $display("FAIL rnd_stb cyc=%0d got=%b expected=%b", i, imem_bus.stb, exp_stb);
      end
      if (exp_stb) begin
        checks++;
        if (imem_bus.addr !== next_fetch) begin
          errors++;
          $display("FAIL rnd_addr cyc=%0d got=%h expected=%h", i, imem_bus.addr, next_fetch);
        end
      end
      exp_valid = (fifo_q.size() > 0) && !redirect;
      checks++;
      if (instr_valid !== exp_valid) begin
        errors++;
        $display("FAIL rnd_valid cyc=%0d got=%b expected=%b", i, instr_valid, exp_valid);
      end
      checks++;
      if (exp_valid) begin
        if (instr !== fifo_q[0].instr || pc !== fifo_q[0].pc) begin
          errors++;
          $display("FAIL rnd_head cyc=%0d instr=%h pc=%h expected %h %h", i, instr, pc, fifo_q[0].instr, fifo_q[0].pc);
        end
      end else if (instr !== NOP_INSN || pc !== 32'h0) begin
        errors++;
        $display("FAIL rnd_idle cyc=%0d instr=%h pc=%h expected %h 0", i, instr, pc, NOP_INSN);
      end
      advance();
    end
  endtask

  initial begin
    imem_bus.stall = 1'b0;
    imem_bus.ack   = 1'b0;
    imem_bus.data  = '0;
    next_fetch     = PC_RESET_DEFAULT;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_ack();
    test_stall();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
